// File: rtl/snd_pkg.sv
// Shared constants, FSM encoding and control-word helpers for the block-aware sender.
package snd_pkg;

  localparam logic [15:0] CH_COMMA = 16'h00BC;
  localparam logic [15:0] CH_TRIG  = 16'h801C;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHead = 2'd1,
    StBody = 2'd2
  } snd_state_e;

  // Length field of a control word: the low lenw bits (lenw <= 32).
  function automatic logic [31:0] cw_len(input logic [63:0] word, input int unsigned lenw);
    logic [63:0] mask;
    mask = (64'd1 << lenw) - 64'd1;
    return 32'(word & mask);
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotated priority encoder: first set bit of req at or after ptr, wrapping at N.
module rr_prio_enc #(
  parameter int unsigned N  = 17,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  int unsigned j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = {{(32 - PW){1'b0}}, ptr} + i;
      if (j >= N) j = j - N;
      if (!found && req[PW'(j)]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/snd_arb_blk.sv
// Block-aware round-robin sender: merges FWFT channel FIFOs into one k-char stream,
// never interleaving blocks, with out-of-band trigger priority and error counters.
module snd_arb_blk
  import snd_pkg::*;
#(
  parameter int unsigned NFIFO = 17,
  parameter int unsigned DW    = 16,
  parameter int unsigned LENW  = 9,
  parameter int unsigned TMO   = 1023,
  parameter int unsigned CNTW  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NFIFO-1:0]    chan_en,
  input  logic [NFIFO-1:0]    fifo_have,
  input  logic [NFIFO*DW-1:0] datain,
  output logic [NFIFO-1:0]    arb_rd,
  input  logic                trig,
  input  logic                cnt_clr,
  output logic [DW-1:0]       dataout,
  output logic                kchar,
  output logic [CNTW-1:0]     cnt_hdr,
  output logic [CNTW-1:0]     cnt_undr,
  output logic [CNTW-1:0]     cnt_tmo,
  output logic                busy
);

  localparam int unsigned PW = (NFIFO > 1) ? $clog2(NFIFO) : 1;
  localparam int unsigned TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [DW-1:0] COMMA = DW'(CH_COMMA);
  localparam logic [DW-1:0] TRIG  = DW'(CH_TRIG);

  snd_state_e       state_q;
  logic [PW-1:0]    rr_ptr_q, sel_q, next_rr;
  logic [LENW-1:0]  remaining_q, word_len;
  logic [TW-1:0]    tmo_q;
  logic [NFIFO-1:0] req;
  logic             found;
  logic [PW-1:0]    idx;
  logic [DW-1:0]    word;
  logic             in_blk, pop, is_cw, fwd, hdr_inc, undr_inc, tmo_hit;

  assign req = fifo_have & chan_en;

  rr_prio_enc #(
    .N  (NFIFO),
    .PW (PW)
  ) u_enc (
    .req   (req),
    .ptr   (rr_ptr_q),
    .found (found),
    .idx   (idx)
  );

  assign in_blk   = (state_q == StHead) || (state_q == StBody);
  assign pop      = in_blk && fifo_have[sel_q] && !trig && !reset;
  assign arb_rd   = pop ? (NFIFO'(1) << sel_q) : '0;
  assign word     = datain[DW*sel_q +: DW];
  assign is_cw    = word[DW-1];
  assign word_len = LENW'(cw_len(64'(word), LENW));
  assign next_rr  = (sel_q == PW'(NFIFO - 1)) ? '0 : sel_q + PW'(1);
  assign busy     = in_blk;

  // Non-CW words seen while awaiting a header are dropped, not forwarded.
  assign fwd      = pop && ((state_q == StBody) || is_cw);
  assign hdr_inc  = pop && (state_q == StHead) && !is_cw;
  assign undr_inc = pop && (state_q == StBody) && is_cw;
  assign tmo_hit  = in_blk && !trig && !fifo_have[sel_q] && (tmo_q == TW'(TMO));

  function automatic logic [CNTW-1:0] cnt_next(input logic [CNTW-1:0] c, input logic inc,
                                               input logic clr);
    if (clr) return '0;
    if (inc && (c != '1)) return c + CNTW'(1);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      remaining_q <= '0;
      tmo_q       <= '0;
      dataout     <= COMMA;
      kchar       <= 1'b1;
      cnt_hdr     <= '0;
      cnt_undr    <= '0;
      cnt_tmo     <= '0;
    end else begin
      dataout  <= trig ? TRIG : (fwd ? word : COMMA);
      kchar    <= trig || !fwd;
      cnt_hdr  <= cnt_next(cnt_hdr, hdr_inc, cnt_clr);
      cnt_undr <= cnt_next(cnt_undr, undr_inc, cnt_clr);
      cnt_tmo  <= cnt_next(cnt_tmo, tmo_hit, cnt_clr);

      unique case (state_q)
        StIdle: begin
          if (found && !trig) begin
            sel_q   <= idx;
            tmo_q   <= '0;
            state_q <= StHead;
          end
        end
        StHead, StBody: begin
          if (!trig) begin
            if (pop) begin
              tmo_q <= '0;
              if (is_cw) begin
                // Early CW in BODY restarts the length count from its own field.
                if (word_len == '0) begin
                  state_q  <= StIdle;
                  rr_ptr_q <= next_rr;
                end else begin
                  remaining_q <= word_len;
                  state_q     <= StBody;
                end
              end else if (state_q == StBody) begin
                remaining_q <= remaining_q - LENW'(1);
                if (remaining_q == LENW'(1)) begin
                  state_q  <= StIdle;
                  rr_ptr_q <= next_rr;
                end
              end
            end else if (tmo_hit) begin
              tmo_q    <= '0;
              state_q  <= StIdle;
              rr_ptr_q <= next_rr;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snd_arb_blk.sv
// Directed self-checking bench for snd_arb_blk with small TMO and CNTW for reachability.
module tb_snd_arb_blk;

  localparam int NF  = 17;
  localparam int TMO = 20;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NF-1:0]   chan_en;
  logic [NF-1:0]   fifo_have;
  logic [NF*16-1:0] datain;
  logic [NF-1:0]   arb_rd;
  logic            trig;
  logic            cnt_clr;
  logic [15:0]     dataout;
  logic            kchar;
  logic [CW-1:0]   cnt_hdr, cnt_undr, cnt_tmo;
  logic            busy;

  snd_arb_blk #(
    .NFIFO (NF),
    .DW    (16),
    .LENW  (9),
    .TMO   (TMO),
    .CNTW  (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chan_en   (chan_en),
    .fifo_have (fifo_have),
    .datain    (datain),
    .arb_rd    (arb_rd),
    .trig      (trig),
    .cnt_clr   (cnt_clr),
    .dataout   (dataout),
    .kchar     (kchar),
    .cnt_hdr   (cnt_hdr),
    .cnt_undr  (cnt_undr),
    .cnt_tmo   (cnt_tmo),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  logic [15:0]   mem [NF][32];
  int            hd [NF];
  int            tl [NF];
  logic [NF-1:0] last_rd;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NF; i++) begin
      if (hd[i] < tl[i]) begin
        fifo_have[i]      = 1'b1;
        datain[16*i +: 16] = mem[i][hd[i]];
      end else begin
        fifo_have[i]      = 1'b0;
        datain[16*i +: 16] = 16'h0000;
      end
    end
  endtask

  task automatic push(input int ch, input logic [15:0] w);
    mem[ch][tl[ch]] = w;
    tl[ch]++;
    drive_inputs();
  endtask

  // One clock: capture the pop strobe before the edge, pop the model FIFOs after it.
  task automatic tick();
    #2;
    last_rd = arb_rd;
    @(posedge clk);
    #1;
    for (int i = 0; i < NF; i++) if (last_rd[i] && hd[i] < tl[i]) hd[i]++;
    drive_inputs();
  endtask

  task automatic out_is(input string tag, input logic [15:0] d, input logic k,
                        input logic [NF-1:0] rd);
    chk({tag, ".data"}, 32'(dataout), 32'(d));
    chk({tag, ".k"}, 32'(kchar), 32'(k));
    chk({tag, ".rd"}, 32'(last_rd), 32'(rd));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NF; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    trig    = 1'b0;
    cnt_clr = 1'b0;
    chan_en = '1;
    last_rd = '0;
    datain  = '0;
    fifo_have = '0;

    // Reset values
    do_reset();
    chk("rst.data", 32'(dataout), 32'h00BC);
    chk("rst.k", 32'(kchar), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.cnt", {cnt_hdr, cnt_undr, cnt_tmo}, 32'd0);

    // Single block on ch0
    push(0, 16'h8002); push(0, 16'h1111); push(0, 16'h2222);
    tick(); out_is("b0.a", 16'h00BC, 1'b1, 17'h0);
    tick(); out_is("b0.b", 16'h8002, 1'b0, 17'h1);
    chk("b0.busy", 32'(busy), 32'd1);
    tick(); out_is("b0.c", 16'h1111, 1'b0, 17'h1);
    tick(); out_is("b0.d", 16'h2222, 1'b0, 17'h1);
    tick(); out_is("b0.e", 16'h00BC, 1'b1, 17'h0);
    chk("b0.idle", 32'(busy), 32'd0);

    // Ch3 then ch5, then rr_ptr=6 must prefer ch7 over ch0
    do_reset();
    push(3, 16'h8001); push(3, 16'h3333); push(5, 16'h8001); push(5, 16'h5555);
    tick(); out_is("rr.a", 16'h00BC, 1'b1, 17'h0);
    tick(); out_is("rr.b", 16'h8001, 1'b0, 17'h8);
    tick(); out_is("rr.c", 16'h3333, 1'b0, 17'h8);
    tick(); out_is("rr.d", 16'h00BC, 1'b1, 17'h0);
    tick(); out_is("rr.e", 16'h8001, 1'b0, 17'h20);
    tick(); out_is("rr.f", 16'h5555, 1'b0, 17'h20);
    push(0, 16'h8000); push(7, 16'h8000);
    tick(); out_is("rr.g", 16'h00BC, 1'b1, 17'h0);
    tick(); out_is("rr.h", 16'h8000, 1'b0, 17'h80);
    tick(); out_is("rr.i", 16'h00BC, 1'b1, 17'h0);
    tick(); out_is("rr.j", 16'h8000, 1'b0, 17'h1);

    // Trigger mid-BODY on ch1
    do_reset();
    push(1, 16'h8003); push(1, 16'h00A1); push(1, 16'h00A2); push(1, 16'h00A3);
    tick(); tick(); tick(); out_is("tg.c", 16'h00A1, 1'b0, 17'h2);
    trig = 1'b1;
    tick(); out_is("tg.d", 16'h801C, 1'b1, 17'h0);
    tick(); out_is("tg.e", 16'h801C, 1'b1, 17'h0);
    trig = 1'b0;
    tick(); out_is("tg.f", 16'h00A2, 1'b0, 17'h2);
    tick(); out_is("tg.g", 16'h00A3, 1'b0, 17'h2);
    tick(); out_is("tg.h", 16'h00BC, 1'b1, 17'h0);

    // Data word in HEAD is dropped
    do_reset();
    push(2, 16'h0005); push(2, 16'h8000);
    tick();
    tick(); out_is("hd.b", 16'h00BC, 1'b1, 17'h4);
    chk("hd.cnt", 32'(cnt_hdr), 32'd1);
    tick(); out_is("hd.c", 16'h8000, 1'b0, 17'h4);

    // Early CW in BODY
    do_reset();
    push(1, 16'h8002); push(1, 16'h0011); push(1, 16'h8001); push(1, 16'h0022);
    tick(); tick(); tick();
    tick(); out_is("ud.d", 16'h8001, 1'b0, 17'h2);
    chk("ud.cnt", 32'(cnt_undr), 32'd1);
    tick(); out_is("ud.e", 16'h0022, 1'b0, 17'h2);
    chk("ud.idle", 32'(busy), 32'd0);

    // Stall timeout then next channel served
    do_reset();
    push(0, 16'h8003); push(0, 16'h0033); push(2, 16'h8000);
    tick(); tick(); tick(); out_is("to.c", 16'h0033, 1'b0, 17'h1);
    for (int i = 0; i < TMO; i++) tick();
    chk("to.pre", 32'(cnt_tmo), 32'd0);
    chk("to.busy", 32'(busy), 32'd1);
    tick();
    chk("to.cnt", 32'(cnt_tmo), 32'd1);
    chk("to.idle", 32'(busy), 32'd0);
    tick(); out_is("to.n1", 16'h00BC, 1'b1, 17'h0);
    tick(); out_is("to.n2", 16'h8000, 1'b0, 17'h4);

    // Masked channel never selected
    do_reset();
    chan_en = ~17'h10;
    push(4, 16'h8000); push(6, 16'h8000);
    tick();
    tick(); out_is("mk.b", 16'h8000, 1'b0, 17'h40);
    tick(); tick(); tick();
    chk("mk.rd", 32'(last_rd), 32'd0);
    chk("mk.busy", 32'(busy), 32'd0);
    chan_en = '1;

    // Saturation and clear priority
    do_reset();
    for (int i = 0; i < 18; i++) push(2, 16'h0001);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("sat.15", 32'(cnt_hdr), 32'd15);
    tick(); tick();
    chk("sat.hold", 32'(cnt_hdr), 32'd15);
    cnt_clr = 1'b1;
    tick();
    chk("clr.pri", 32'(cnt_hdr), 32'd0);
    chk("clr.rd", 32'(last_rd), 32'h4);
    cnt_clr = 1'b0;

    // Reset mid-block
    do_reset();
    push(0, 16'h8005); push(0, 16'h0001); push(0, 16'h0002);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("mr.rd", 32'(arb_rd), 32'd0);
    tick();
    out_is("mr.out", 16'h00BC, 1'b1, 17'h0);
    chk("mr.busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snd_arb_blk.md
Name: snd_arb_blk

Overview:
- Block-aware round-robin sender feeding the GTP transmit lane; parametrised successor of the channel sender.
- Merges NFIFO first-word-fall-through channel FIFOs into one DW-bit k-char stream.
- Sends the trigger K-char out of band with absolute priority.
- Guarantees whole blocks (control word plus LEN data words) are never interleaved. Adds skip-empty arbitration, channel masking, a stall timeout and saturating error counters.

Parameters:
- NFIFO, 17, number of channel FIFOs (2..32).
- DW, 16, data word width; bit DW-1 marks a control word (CW).
- LENW, 9, width of the CW length field (CW[LENW-1:0] = data words following the CW).
- TMO, 1023, idle-cycle limit inside a block before it is abandoned.
- CNTW, 16, width of the error counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- chan_en  in  NFIFO  per-channel enable mask; disabled channels are never selected.
- fifo_have  in  NFIFO  FWFT valid; datain slice i is valid while bit i is high.
- datain  in  NFIFO*DW  channel data, channel i at [DW*i +: DW].
- arb_rd  out  NFIFO  combinational pop strobe, one-hot or zero.
- trig  in  1  trigger request from the summing block.
- cnt_clr  in  1  clears all error counters.
- dataout  out  DW  registered GTP data.
- kchar  out  1  registered k-char flag.
- cnt_hdr, cnt_undr, cnt_tmo  out  CNTW each  saturating error counters.
- busy  out  1  high while in BLOCK state.

Behaviour:
- Reset: state IDLE, rr_ptr=0, sel=0, remaining=0, tmo_cnt=0, dataout=CH_COMMA (16'h00BC zero-extended to DW), kchar=1, counters=0. arb_rd is 0 whenever reset is high.
- Output encoding: CH_TRIG=16'h801C sent with kchar=1. Data sent with kchar=0. Every cycle with no trigger and no popped word sends CH_COMMA with kchar=1.
- Latency: a word popped in cycle n appears on dataout in cycle n+1.
- Trigger priority: when trig=1, the next output is CH_TRIG, arb_rd=0, and state, remaining and tmo_cnt are frozen. No data word is lost.
- IDLE:
  - req = fifo_have & chan_en, rotated to start at rr_ptr. A rotated priority encoder picks the first set bit.
  - If req≠0 and trig=0: sel<=found index; go to HEAD. No pop this cycle; output is comma.
  - rr_ptr is not changed in IDLE.
- HEAD (awaiting CW):
  - arb_rd[sel]=fifo_have[sel]&~trig.
  - Popped word with MSB=1: forward it. If len=0, block ends (see End of block). Otherwise remaining<=len and go to BODY.
  - Popped word with MSB=0: drop it (not forwarded), cnt_hdr++, send comma, stay in HEAD.
- BODY:
  - arb_rd[sel]=fifo_have[sel]&~trig.
  - Popped data word (MSB=0): forward it, remaining--. If remaining reaches 0, block ends.
  - Popped CW (MSB=1): early CW. cnt_undr++, forward it, remaining<=its len (restart). If len=0, block ends.
- End of block: go to IDLE with rr_ptr<=(sel==NFIFO-1)?0:sel+1.
- Stall: in HEAD or BODY, each non-trigger cycle with fifo_have[sel]=0 increments tmo_cnt; any pop clears it. When tmo_cnt==TMO: cnt_tmo++, go to IDLE, rr_ptr<=sel+1 (wrapped), tmo_cnt<=0.
- chan_en deasserted for sel mid-block: ignored until the block ends or times out.
- Counters: saturate at all-ones. cnt_clr has priority over a same-cycle increment.
- Reset mid-block: everything returns to reset values immediately. A partially sent block is not completed; the receiver resynchronises on the next CW.

Decomposition:
- Shared package snd_pkg: CH_COMMA, CH_TRIG, state encoding (IDLE, HEAD, BODY), cw_len extraction function.
- One sub-module: rr_prio_enc (NFIFO-wide rotated priority encoder; inputs req and ptr, outputs found and idx).

Test Plan:
- Ch0 holds CW 16'h8002 plus two data words, others empty → dataout shows comma, 8002, d0, d1, then commas. arb_rd[0] is high for 3 cycles.
- Ch3 and ch5 each hold a 1-word-len block, rr_ptr=0 → ch3's block is sent completely before ch5's, then rr_ptr=6.
- trig pulsed for 2 cycles mid-BODY of a ch1 block → two 801C k-chars, no pops in those cycles, then the block resumes with no word lost or duplicated.
- Ch2 delivers data word 16'h0005 while in HEAD → word dropped, cnt_hdr=1; the following CW 8000 is forwarded.
- CW 8003, one data word, then ch empties for TMO+1 cycles → cnt_tmo=1, back to IDLE, next enabled channel is served.
- chan_en=0 on ch4 with data present → ch4 is never selected. Counter held at all-ones with further errors → stays at all-ones. cnt_clr → 0.
